// File: rtl/alu1_operand_pipe_pkg.sv
// Shared definitions for the ALU operand-1 selector: select encodings and widths.
package alu1_operand_pipe_pkg;

    localparam int unsigned ALU1_REG_LEN = 32;
    localparam int unsigned ALU1_SEL_W   = 3;

    localparam logic [ALU1_SEL_W-1:0] ALU1_RS   = 3'd0;
    localparam logic [ALU1_SEL_W-1:0] ALU1_PC   = 3'd1;
    localparam logic [ALU1_SEL_W-1:0] ALU1_IMM  = 3'd2;
    localparam logic [ALU1_SEL_W-1:0] ALU1_FWD  = 3'd3;
    localparam logic [ALU1_SEL_W-1:0] ALU1_ZERO = 3'd4;

    // True for the five defined source encodings; 5..7 are illegal.
    function automatic logic alu1_sel_legal(input logic [ALU1_SEL_W-1:0] sel);
        return (sel <= ALU1_ZERO);
    endfunction

endpackage

// File: rtl/alu1_operand_pipe_pc_delay.sv
// PC history delay line: PC_DELAY stages of {data, vld}, oldest at index 0.
module pc_delay_line
    import alu1_operand_pipe_pkg::*;
#(
    parameter int unsigned REG_LEN  = ALU1_REG_LEN,
    parameter int unsigned PC_DELAY = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               clr,
    input  logic [REG_LEN-1:0] d,
    input  logic               d_vld,
    output logic [REG_LEN-1:0] q,
    output logic               q_vld
);

    logic [REG_LEN-1:0]  r_data [PC_DELAY];
    logic [PC_DELAY-1:0] r_vld;

    // Shift history toward index 0 on each advance; reset and clear wipe it.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int unsigned i = 0; i < PC_DELAY; i++) begin
                r_data[i] <= '0;
            end
            r_vld <= '0;
        end else if (en) begin
            r_data[PC_DELAY-1] <= d;
            r_vld[PC_DELAY-1]  <= d_vld;
            for (int unsigned i = 0; i + 1 < PC_DELAY; i++) begin
                r_data[i] <= r_data[i+1];
                r_vld[i]  <= r_vld[i+1];
            end
        end
    end

    assign q     = r_data[0];
    assign q_vld = r_vld[0];

endmodule

// File: rtl/alu1_operand_pipe.sv
// ALU operand-1 selector: PC history alignment, 5-way source mux, registered output.
module alu1_operand_pipe
    import alu1_operand_pipe_pkg::*;
#(
    parameter int unsigned REG_LEN  = ALU1_REG_LEN,
    parameter int unsigned PC_DELAY = 2,
    parameter int unsigned SEL_W    = ALU1_SEL_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               flush,
    input  logic [REG_LEN-1:0] pc,
    input  logic               pc_valid,
    input  logic [REG_LEN-1:0] rs1_d,
    input  logic [REG_LEN-1:0] imm,
    input  logic [REG_LEN-1:0] fwd_d,
    input  logic [SEL_W-1:0]   alu1_sel,
    output logic [REG_LEN-1:0] alu_in1,
    output logic               alu_in1_vld,
    output logic               pc_hist_rdy,
    output logic               sel_err
);

    logic [REG_LEN-1:0] w_hist_q;
    logic               w_hist_vld;
    logic [REG_LEN-1:0] w_nxt_data;
    logic               w_nxt_vld;
    logic               w_nxt_err;

    logic [REG_LEN-1:0] r_alu_in1;
    logic               r_alu_in1_vld;
    logic               r_sel_err;

    pc_delay_line #(
        .REG_LEN  (REG_LEN),
        .PC_DELAY (PC_DELAY)
    ) u_pc_delay_line (
        .clk   (clk),
        .rst   (rst),
        .en    (!stall),
        .clr   (flush),
        .d     (pc),
        .d_vld (pc_valid),
        .q     (w_hist_q),
        .q_vld (w_hist_vld)
    );

    // Source select; PC reads the oldest history stage before this edge's shift.
    always_comb begin
        w_nxt_data = '0;
        w_nxt_vld  = 1'b0;
        w_nxt_err  = 1'b0;
        case (alu1_sel)
            SEL_W'(ALU1_RS):   begin w_nxt_data = rs1_d; w_nxt_vld = 1'b1; end
            SEL_W'(ALU1_PC):   begin
                w_nxt_data = w_hist_vld ? w_hist_q : '0;
                w_nxt_vld  = w_hist_vld;
            end
            SEL_W'(ALU1_IMM):  begin w_nxt_data = imm;   w_nxt_vld = 1'b1; end
            SEL_W'(ALU1_FWD):  begin w_nxt_data = fwd_d; w_nxt_vld = 1'b1; end
            SEL_W'(ALU1_ZERO): begin w_nxt_data = '0;    w_nxt_vld = 1'b1; end
            default:           w_nxt_err = 1'b1;
        endcase
    end

    // Output register: flush clears it even while stalled; stall alone holds it.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_alu_in1     <= '0;
            r_alu_in1_vld <= 1'b0;
            r_sel_err     <= 1'b0;
        end else if (!stall) begin
            r_alu_in1     <= w_nxt_data;
            r_alu_in1_vld <= w_nxt_vld;
            r_sel_err     <= w_nxt_err;
        end
    end

    assign alu_in1     = r_alu_in1;
    assign alu_in1_vld = r_alu_in1_vld;
    assign sel_err     = r_sel_err;
    assign pc_hist_rdy = w_hist_vld;

endmodule

// File: tb/tb_alu1_operand_pipe.sv
// Self-checking bench for alu1_operand_pipe with PC_DELAY=2.
module tb_alu1_operand_pipe;

    typedef struct {
        bit          rst;
        bit          stall;
        bit          flush;
        bit          pcv;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] imm;
        logic [31:0] fwd;
        logic [2:0]  sel;
        logic [31:0] e_out;
        bit          e_vld;
        bit          e_err;
        bit          e_rdy;
    } vec_t;

    typedef struct {
        int          idx;
        logic [31:0] out;
        bit          vld;
        bit          err;
        bit          rdy;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [31:0] pc;
    logic        pc_valid;
    logic [31:0] rs1_d;
    logic [31:0] imm;
    logic [31:0] fwd_d;
    logic [2:0]  alu1_sel;
    logic [31:0] alu_in1;
    logic        alu_in1_vld;
    logic        pc_hist_rdy;
    logic        sel_err;

    int n_vec  = 0;
    int n_fail = 0;

    vec_t vecs[$];
    exp_t exp_q[$];

    alu1_operand_pipe #(
        .REG_LEN  (32),
        .PC_DELAY (2),
        .SEL_W    (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .flush       (flush),
        .pc          (pc),
        .pc_valid    (pc_valid),
        .rs1_d       (rs1_d),
        .imm         (imm),
        .fwd_d       (fwd_d),
        .alu1_sel    (alu1_sel),
        .alu_in1     (alu_in1),
        .alu_in1_vld (alu_in1_vld),
        .pc_hist_rdy (pc_hist_rdy),
        .sel_err     (sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    function automatic vec_t mk(bit r, bit st, bit fl, bit pv, logic [31:0] p,
                                logic [31:0] rs, logic [31:0] im, logic [31:0] fw,
                                logic [2:0] s, logic [31:0] eo, bit ev, bit ee, bit er);
        vec_t v;
        v.rst = r; v.stall = st; v.flush = fl; v.pcv = pv; v.pc = p;
        v.rs1 = rs; v.imm = im; v.fwd = fw; v.sel = s;
        v.e_out = eo; v.e_vld = ev; v.e_err = ee; v.e_rdy = er;
        return v;
    endfunction

    task automatic check(input int idx, input string name,
                         input logic [31:0] act, input logic [31:0] want);
        if (act !== want) begin
            n_fail++;
            $display("FAIL v%0d %s: got %h want %h", idx, name, act, want);
        end
    endtask

    // Drive one vector at negedge, queue its expectation, compare after the edge.
    task automatic apply(input int idx, input vec_t v);
        exp_t e;
        exp_t g;
        rst      = v.rst;
        stall    = v.stall;
        flush    = v.flush;
        pc_valid = v.pcv;
        alu1_sel = v.sel;
        if (v.rst) begin
            pc    = $urandom;
            rs1_d = $urandom;
            imm   = $urandom;
            fwd_d = $urandom;
        end else begin
            pc    = v.pc;
            rs1_d = v.rs1;
            imm   = v.imm;
            fwd_d = v.fwd;
        end
        e.idx = idx; e.out = v.e_out; e.vld = v.e_vld; e.err = v.e_err; e.rdy = v.e_rdy;
        exp_q.push_back(e);
        n_vec++;
        @(posedge clk);
        #1;
        g = exp_q.pop_front();
        check(g.idx, "alu_in1",     alu_in1,             g.out);
        check(g.idx, "alu_in1_vld", {31'd0, alu_in1_vld}, {31'd0, g.vld});
        check(g.idx, "sel_err",     {31'd0, sel_err},     {31'd0, g.err});
        check(g.idx, "pc_hist_rdy", {31'd0, pc_hist_rdy}, {31'd0, g.rdy});
        @(negedge clk);
    endtask

    initial begin
        int found;
        rst = 1'b1; stall = 1'b0; flush = 1'b0; pc = '0; pc_valid = 1'b0;
        rs1_d = '0; imm = '0; fwd_d = '0; alu1_sel = 3'd0;

        //                rst st fl pv pc          rs1           imm       fwd        sel   exp_out       vld err rdy
        // reset with random data
        vecs.push_back(mk(1, 0, 0, 1, 32'h0,      32'h0,        32'h0,    32'h0,     3'd0, 32'h0,        0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 1, 32'h0,      32'h0,        32'h0,    32'h0,     3'd2, 32'h0,        0, 0, 0));
        // direct sources
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,      32'h12,       32'h0,    32'h0,     3'd0, 32'h12,       1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,      32'h0,        32'h0,    32'hDEAD,  3'd3, 32'hDEAD,     1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,      32'h0,        32'h3C,   32'h0,     3'd2, 32'h3C,       1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,      32'hFFFF,     32'h1,    32'h2,     3'd4, 32'h0,        1, 0, 0));
        // PC delay: pushes 0x100.. with sel=PC
        vecs.push_back(mk(0, 0, 0, 1, 32'h100,    32'h0,        32'h0,    32'h0,     3'd1, 32'h0,        0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 32'h104,    32'h0,        32'h0,    32'h0,     3'd1, 32'h0,        0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 32'h108,    32'h0,        32'h0,    32'h0,     3'd1, 32'h100,      1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 32'h10C,    32'h0,        32'h0,    32'h0,     3'd1, 32'h104,      1, 0, 1));
        // stall two cycles with pc=0x200 never pushed
        vecs.push_back(mk(0, 1, 0, 1, 32'h200,    32'h0,        32'h0,    32'h0,     3'd1, 32'h104,      1, 0, 1));
        vecs.push_back(mk(0, 1, 0, 1, 32'h200,    32'h99,       32'h0,    32'h0,     3'd0, 32'h104,      1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 32'h110,    32'h0,        32'h0,    32'h0,     3'd1, 32'h108,      1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 32'h114,    32'h0,        32'h0,    32'h0,     3'd1, 32'h10C,      1, 0, 1));
        // flush together with stall, then refill
        vecs.push_back(mk(0, 1, 1, 1, 32'h300,    32'h0,        32'h0,    32'h0,     3'd1, 32'h0,        0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 32'h400,    32'h0,        32'h0,    32'h0,     3'd1, 32'h0,        0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 32'h404,    32'h0,        32'h0,    32'h0,     3'd1, 32'h0,        0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 32'h408,    32'h0,        32'h0,    32'h0,     3'd1, 32'h400,      1, 0, 1));
        // illegal selects
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,      32'h55,       32'h0,    32'h0,     3'd7, 32'h0,        0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,      32'h55,       32'h0,    32'h0,     3'd0, 32'h55,       1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,      32'h66,       32'h0,    32'h0,     3'd5, 32'h0,        0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 32'h0,      32'h77,       32'h0,    32'h0,     3'd0, 32'h0,        0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 32'h0,      32'h0,        32'h0,    32'h0,     3'd6, 32'h0,        0, 0, 0));
        // reset while stalled wins
        vecs.push_back(mk(0, 0, 0, 1, 32'h500,    32'h0,        32'hAB,   32'h0,     3'd2, 32'hAB,       1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 32'h504,    32'h0,        32'hAB,   32'h0,     3'd2, 32'hAB,       1, 0, 1));
        vecs.push_back(mk(1, 1, 0, 1, 32'h0,      32'h0,        32'h0,    32'h0,     3'd0, 32'h0,        0, 0, 0));
        // full-width passthrough
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,      32'hFFFFFFFF, 32'h0,    32'h0,     3'd0, 32'hFFFFFFFF, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,      32'h0,        32'h0,    32'h80000001, 3'd3, 32'h80000001, 1, 0, 0));

        @(negedge clk);
        foreach (vecs[i]) apply(i, vecs[i]);

        // PC pushed once becomes selectable exactly PC_DELAY edges later.
        rst = 1'b0; stall = 1'b0; flush = 1'b0;
        pc = 32'h600; pc_valid = 1'b1; alu1_sel = 3'd0; rs1_d = 32'h0;
        @(posedge clk);
        @(negedge clk);
        pc = 32'h0; pc_valid = 1'b0; alu1_sel = 3'd1;
        found = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            if (found == 0 && alu_in1 === 32'h600 && alu_in1_vld === 1'b1) found = k;
        end
        n_vec++;
        check(n_vec - 1, "pc_latency_edges", found, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
